// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: the hex font, the reader FSM state codes,
// the blank bus code and the default digit count.
package sevenseg_pkg;

  localparam int DEFAULT_DIGITS = 4;

  // Active-high segment patterns, gfedcba order (bit0 = a).
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // All segments off as seen on the active-low bus.
  localparam logic [6:0] BLANK_SEG_N = 7'h7F;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLE   = 2'd1;
  localparam logic [1:0] ST_CAPTURED = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    SETTLE   = ST_SETTLE,
    CAPTURED = ST_CAPTURED
  } state_e;

  // Forward hex-to-segment decode; the reader inverts this table.
  function automatic logic [6:0] seg_encode(input logic [3:0] value);
    case (value)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/sevenseg_pattern_lookup.sv
// Combinational reverse decode of an active-high gfedcba pattern to its hex
// value; hit is low for any pattern outside the 16-entry font.
module sevenseg_pattern_lookup
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] hex
);

  logic [15:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign match[gi] = (pattern == seg_encode(4'(gi)));
    end
  endgenerate

  // Font entries are distinct, so at most one match bit is ever set.
  always_comb begin
    hit = |match;
    hex = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (match[i]) begin
        hex = 4'(i);
      end
    end
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Seven-segment bus reader: debounces the multiplexed display lines and stores
// the reverse-decoded value per digit. Option macro: SEVENSEG_READER_BLANK_EN.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int K_DIGITS = DEFAULT_DIGITS,
  parameter int K_STABLE = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_seg_n,
  input  logic [K_DIGITS-1:0]   i_an_n,
  output logic [4*K_DIGITS-1:0] o_hex,
  output logic [K_DIGITS-1:0]   o_valid_mask,
  output logic                  o_err,
  output logic                  o_frame_done
);

  localparam int SW = K_DIGITS + 7;
  localparam int CW = (K_STABLE > 2) ? $clog2(K_STABLE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(K_STABLE - 1);

`ifdef SEVENSEG_READER_BLANK_EN
  localparam logic BLANK_LEGAL = 1'b1;
`else
  localparam logic BLANK_LEGAL = 1'b0;
`endif

  logic [SW-1:0]         sample_reg;
  logic [SW-1:0]         sample_next;
  logic                  changed;
  logic [CW-1:0]         cnt_reg;
  logic [CW-1:0]         cnt_next;
  logic [1:0]            state_reg;
  logic [1:0]            state_next;

  logic [K_DIGITS-1:0]   an_n;
  logic [6:0]            seg_n;
  logic [6:0]            seg;
  logic [K_DIGITS-1:0]   digit_sel;
  logic                  one_hot;
  logic                  commit;

  logic                  lut_hit;
  logic [3:0]            lut_hex;
  logic                  write_hit;
  logic                  write_blank;

  logic [4*K_DIGITS-1:0] hex_reg;
  logic [4*K_DIGITS-1:0] hex_next;
  logic [K_DIGITS-1:0]   mask_reg;
  logic [K_DIGITS-1:0]   mask_next;
  logic [K_DIGITS-1:0]   acc_reg;
  logic [K_DIGITS-1:0]   acc_set;
  logic [K_DIGITS-1:0]   acc_next;
  logic                  err_reg;
  logic                  err_next;
  logic                  frame_reg;
  logic                  frame_next;

  // Stability is judged against the incoming sample so the count restarts on
  // the same edge that captures a new bus value.
  assign sample_next = {i_an_n, i_seg_n};
  assign changed     = (sample_next != sample_reg);

  always_comb begin
    cnt_next = cnt_reg;
    if (changed) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign an_n      = sample_reg[SW-1:7];
  assign seg_n     = sample_reg[6:0];
  assign seg       = ~seg_n;
  assign digit_sel = ~an_n;
  assign one_hot   = $onehot(digit_sel);
  assign commit    = (state_reg == ST_SETTLE) && one_hot && (cnt_reg == CNT_MAX);

  // cnt_reg only reads zero on the cycle right after S changed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (one_hot) state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!one_hot)    state_next = ST_IDLE;
        else if (commit) state_next = ST_CAPTURED;
      end
      ST_CAPTURED: begin
        if (cnt_reg == '0) state_next = one_hot ? ST_SETTLE : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  sevenseg_pattern_lookup u_lookup (
    .pattern (seg),
    .hit     (lut_hit),
    .hex     (lut_hex)
  );

  assign write_hit   = commit & lut_hit;
  assign write_blank = BLANK_LEGAL & commit & ~lut_hit & (seg_n == BLANK_SEG_N);
  assign err_next    = commit & ~lut_hit & ~write_blank;

  genvar gi;
  generate
    for (gi = 0; gi < K_DIGITS; gi++) begin : g_digit
      assign hex_next[4*gi +: 4] = (write_hit & digit_sel[gi]) ? lut_hex : hex_reg[4*gi +: 4];
      assign mask_next[gi] = (write_hit & digit_sel[gi])   ? 1'b1 :
                             (write_blank & digit_sel[gi]) ? 1'b0 : mask_reg[gi];
      assign acc_set[gi]   = acc_reg[gi] | ((write_hit | write_blank) & digit_sel[gi]);
    end
  endgenerate

  // The accumulator never rests at all-ones: completing it clears it at once.
  assign frame_next = (write_hit | write_blank) & (&acc_set);
  assign acc_next   = frame_next ? '0 : acc_set;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sample_reg <= '1;
      cnt_reg    <= '0;
      state_reg  <= ST_IDLE;
      hex_reg    <= '0;
      mask_reg   <= '0;
      acc_reg    <= '0;
      err_reg    <= 1'b0;
      frame_reg  <= 1'b0;
    end else begin
      sample_reg <= sample_next;
      cnt_reg    <= cnt_next;
      state_reg  <= state_next;
      hex_reg    <= hex_next;
      mask_reg   <= mask_next;
      acc_reg    <= acc_next;
      err_reg    <= err_next;
      frame_reg  <= frame_next;
    end
  end

  assign o_hex        = hex_reg;
  assign o_valid_mask = mask_reg;
  assign o_err        = err_reg;
  assign o_frame_done = frame_reg;

endmodule
